peripheral_arbiter_ahb3: RTL and testbench

Round-robin bus arbiter for the shared AHB3 peripheral bus in the MPSoC tile. It lets up to `MASTERS` requesters (core instruction/data ports, DMA, debug) share one address/data bus and drives the grant, master-select and lock signals that steer the bus multiplexers. Fixed-length bursts and locked sequences are never interrupted. With no requests, the bus is parked on a default master.

---
 rtl/peripheral_ahb3_pkg.sv | 38 +++
 rtl/peripheral_rr_select_ahb3.sv | 37 +++
 rtl/peripheral_arbiter_ahb3.sv | 140 ++++++++++++++
 tb/tb_peripheral_arbiter_ahb3.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// rtl/peripheral_ahb3_pkg.sv - shared AHB3 transfer/burst codes, arbiter states and burst length lookup
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_BURST  = 2'd2,
        ARB_LOCKED = 2'd3
    } arb_state_t;

    // Total beats of a fixed-length burst; 0 means the burst is not protected
    // (SINGLE, INCR and any unrecognised code behave like INCR).
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/peripheral_rr_select_ahb3.sv
// rtl/peripheral_rr_select_ahb3.sv - combinational round-robin picker scanning upward from pointer+1
module peripheral_rr_select_ahb3
    import peripheral_ahb3_pkg::*;
#(
    parameter int MASTERS = 4,
    localparam int MW = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0] req,
    input  logic [MW-1:0]      ptr,
    output logic [MASTERS-1:0] winner,
    output logic [MW-1:0]      index,
    output logic               any
);

    logic [MW-1:0] cand;
    logic          found;

    // First asserted request after the pointer wins; the pointer itself is
    // scanned last, so a lone current owner keeps the bus.
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            cand = MW'((int'(ptr) + i) % MASTERS);
            if (!found && req[cand]) begin
                found         = 1'b1;
                winner[cand]  = 1'b1;
                index         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/peripheral_arbiter_ahb3.sv
// rtl/peripheral_arbiter_ahb3.sv - round-robin AHB3 bus arbiter with burst and lock protection
module peripheral_arbiter_ahb3
    import peripheral_ahb3_pkg::*;
#(
    parameter int MASTERS        = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(MASTERS)
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [MASTERS-1:0] HBUSREQ,
    input  logic [MASTERS-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic               HRESP,
    output logic [MASTERS-1:0] HGRANT,
    output logic [MW-1:0]      HMASTER,
    output logic [MW-1:0]      HMASTER_D,
    output logic               HMASTLOCK
);

    localparam logic [MW-1:0]      DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [MASTERS-1:0] DEF_GRANT = MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t         state, state_n;
    logic [MW-1:0]      ptr, ptr_n;
    logic [MW-1:0]      owner, owner_n;
    logic [3:0]         cnt, cnt_n;
    logic [MASTERS-1:0] grant_n;
    logic [4:0]         beats;
    logic               arb;

    logic [MASTERS-1:0] win_onehot;
    logic [MW-1:0]      win_idx;
    logic               win_any;

    peripheral_rr_select_ahb3 #(
        .MASTERS (MASTERS)
    ) u_rr_select (
        .req    (HBUSREQ),
        .ptr    (ptr),
        .winner (win_onehot),
        .index  (win_idx),
        .any    (win_any)
    );

    // Next-state: burst/lock tracking decides whether this edge may re-arbitrate.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        grant_n = HGRANT;
        arb     = 1'b0;
        beats   = burst_beats(HBURST);

        case (state)
            ARB_PARK, ARB_OWNED: begin
                if (HREADY) begin
                    if (HTRANS == HTRANS_NONSEQ && beats != 5'd0) begin
                        state_n = ARB_BURST;
                        cnt_n   = 4'(beats - 5'd1);
                    end else begin
                        arb = 1'b1;
                    end
                end
            end
            ARB_BURST: begin
                if (HREADY) begin
                    if (HRESP) begin
                        cnt_n   = 4'd0;
                        state_n = ARB_OWNED;
                    end else if (HTRANS == HTRANS_SEQ) begin
                        cnt_n = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state_n = ARB_OWNED;
                            arb     = 1'b1;
                        end
                    end else if (HTRANS != HTRANS_BUSY) begin
                        cnt_n   = 4'd0;
                        state_n = ARB_OWNED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (!HLOCK[owner]) begin
                    state_n = ARB_OWNED;
                end
            end
            default: begin
                state_n = ARB_OWNED;
            end
        endcase

        if (arb) begin
            if (win_any) begin
                grant_n = win_onehot;
                owner_n = win_idx;
                ptr_n   = win_idx;
                state_n = HLOCK[win_idx] ? ARB_LOCKED : ARB_OWNED;
            end else begin
                grant_n = DEF_GRANT;
                owner_n = DEF_IDX;
                state_n = ARB_PARK;
            end
        end
    end

    // Arbitration state and the registered grant.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= ARB_PARK;
            ptr    <= DEF_IDX;
            owner  <= DEF_IDX;
            cnt    <= 4'd0;
            HGRANT <= DEF_GRANT;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            cnt    <= cnt_n;
            HGRANT <= grant_n;
        end
    end

    // Address/data-phase owner pipeline advances only when a transfer completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HMASTER   <= DEF_IDX;
            HMASTER_D <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            HMASTER   <= owner;
            HMASTER_D <= HMASTER;
            HMASTLOCK <= HLOCK[owner];
        end
    end

endmodule

// File: tb/tb_peripheral_arbiter_ahb3.sv
// tb/tb_peripheral_arbiter_ahb3.sv - scoreboard bench for the round-robin AHB3 arbiter
module tb_peripheral_arbiter_ahb3;
    import peripheral_ahb3_pkg::*;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic       HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    peripheral_arbiter_ahb3 #(
        .MASTERS        (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 1'b0;

    // Reference model: owner, rotation pointer, beats still owed to a burst, lock hold.
    int m_owner, m_ptr, m_left, m_master, m_master_d;
    bit m_lock, m_mastlock;

    function automatic int burst_len(input logic [2:0] b);
        int code;
        code = int'(b);
        return (code >= 2) ? (4 << ((code - 2) / 2)) : 0;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                              input logic [1:0] tr, input logic [2:0] bu,
                              input logic rdy, input logic rs);
        int old_owner;
        int w;
        bit arb;
        logic [1:0] j;
        if (rst) begin
            m_owner = 0; m_ptr = 0; m_left = 0; m_lock = 0;
            m_master = 0; m_master_d = 0; m_mastlock = 0;
            return;
        end
        old_owner = m_owner;
        arb = 0;
        if (m_lock) begin
            if (!lk[2'(m_owner)]) m_lock = 0;
        end else if (rdy) begin
            if (m_left > 0) begin
                if (rs) m_left = 0;
                else if (tr == HTRANS_SEQ) begin
                    m_left = m_left - 1;
                    arb = (m_left == 0);
                end else if (tr != HTRANS_BUSY) m_left = 0;
            end else if (tr == HTRANS_NONSEQ && burst_len(bu) > 0) begin
                m_left = burst_len(bu) - 1;
            end else begin
                arb = 1;
            end
        end
        if (arb) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                j = 2'((m_ptr + k) % 4);
                if (w < 0 && req[j]) w = int'(j);
            end
            if (w < 0) m_owner = 0;
            else begin
                m_owner = w;
                m_ptr   = w;
                m_lock  = lk[2'(w)];
            end
        end
        if (rdy) begin
            m_master_d = m_master;
            m_master   = old_owner;
            m_mastlock = lk[2'(old_owner)];
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: apply inputs, predict the post-edge outputs, wait one cycle.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                         input logic [1:0] tr, input logic [2:0] bu,
                         input logic rdy, input logic rs);
        exp_t e;
        HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rs;
        HRESET  = rst;
        if (rst) begin
            #1;
            chk("async_reset_grant", int'(HGRANT), 1);
            chk("async_reset_master", int'(HMASTER), 0);
            chk("async_reset_mastlock", int'(HMASTLOCK), 0);
        end
        model_step(rst, req, lk, tr, bu, rdy, rs);
        e.g  = 4'(1 << m_owner);
        e.m  = 2'(m_master);
        e.md = 2'(m_master_d);
        e.ml = m_mastlock;
        sb.push_back(e);
        @(negedge HCLK);
    endtask

    // Monitor: every post-edge sample is compared against the oldest prediction.
    initial begin
        exp_t e;
        @(negedge HCLK);
        forever begin
            @(posedge HCLK);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end
            end else begin
                e = sb.pop_front();
                checks++;
                if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t got grant=%b master=%0d master_d=%0d mastlock=%b expected grant=%b master=%0d master_d=%0d mastlock=%b",
                             $time, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, e.g, e.m, e.md, e.ml);
                end
            end
        end
    end

    int rr_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = HTRANS_IDLE;
        HBURST = HBURST_SINGLE; HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);

        // reset / park
        repeat (3) drive(1, 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("reset_grant", int'(HGRANT), 1);
        chk("reset_master_d", int'(HMASTER_D), 0);

        // round robin with all masters requesting
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0);
            chk("rr_grant", int'(HGRANT), 1 << rr_exp[i]);
            if (i > 0) chk("rr_master_lag", int'(HMASTER), rr_exp[i-1]);
        end

        // INCR4 protection with a BUSY after beat 2
        drive(0, 4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("incr4_owner", int'(HGRANT), 4);
        drive(0, 4'b1100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1, 0);
        drive(0, 4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 0);
        drive(0, 4'b1100, 4'b0000, HTRANS_BUSY,   HBURST_INCR4, 1, 0);
        drive(0, 4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 0);
        chk("incr4_hold", int'(HGRANT), 4);
        drive(0, 4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4, 1, 0);
        chk("incr4_handoff", int'(HGRANT), 8);

        // reset in the middle of an INCR8
        drive(0, 4'b1000, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1, 0);
        drive(0, 4'b1000, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1, 0);
        drive(1, 4'b1000, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1, 0);
        drive(1, 4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1, 0);

        // wait states during a handoff
        drive(0, 4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        repeat (5) drive(0, 4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 0, 0);
        chk("wait_grant_frozen", int'(HGRANT), 2);
        chk("wait_master_frozen", int'(HMASTER), 0);
        drive(0, 4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("wait_grant_advance", int'(HGRANT), 4);
        chk("wait_master_advance", int'(HMASTER), 1);

        // locked sequence by master 1
        drive(0, 4'b0010, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        repeat (10) drive(0, 4'b1111, 4'b0010, 2'($urandom), 3'($urandom), 1, 1'($urandom_range(0, 1)));
        chk("lock_grant", int'(HGRANT), 2);
        chk("lock_mastlock", int'(HMASTLOCK), 1);
        drive(0, 4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        drive(0, 4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("lock_release_grant", int'(HGRANT), 4);

        // INCR8 cut short by IDLE after 3 beats
        drive(0, 4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1, 0);
        repeat (2) drive(0, 4'b0100, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, 0);
        drive(0, 4'b1100, 4'b0000, HTRANS_IDLE, HBURST_INCR8, 1, 0);
        chk("early_term_hold", int'(HGRANT), 4);
        drive(0, 4'b1100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("early_term_rearb", int'(HGRANT), 8);

        // INCR8 cut short by ERROR at beat 5
        drive(0, 4'b1000, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1, 0);
        repeat (3) drive(0, 4'b1000, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, 0);
        drive(0, 4'b1001, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1, 1);
        chk("error_hold", int'(HGRANT), 8);
        drive(0, 4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1, 0);
        chk("error_rearb", int'(HGRANT), 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 499) == 0),
                  4'($urandom),
                  4'($urandom & $urandom & $urandom),
                  2'($urandom),
                  3'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        done = 1'b1;
        @(posedge HCLK);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
